// File: rtl/vs_rate_gen_pkg.sv
// Shared video-timing definitions: sync-generator FSM states, default clock rate
// and the frame-rate clamp helper. Also imported by the FPS monitor.
package vs_rate_gen_pkg;

    // Pacer FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2
    } vs_state_e;

    // Default system clock rate in Hz; also the tick accumulator modulus.
    localparam int unsigned DefClkHz = 32'd50_000_000;

    // Limit a requested frame rate to the configured ceiling.
    function automatic logic [7:0] clamp_fps(input logic [7:0] req, input logic [7:0] ceiling);
        return (req > ceiling) ? ceiling : req;
    endfunction

endpackage

// File: rtl/vs_rate_gen_frac_tick_acc.sv
// frac_tick_acc: fractional rate accumulator. Adds i_rate every running cycle and
// emits o_tick whenever the sum wraps CLK_HZ, so exactly i_rate ticks occur per
// CLK_HZ cycles.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           preload the accumulator (takes priority over i_run)
//   i_load_rate      rate used to compute the preload value
//   i_run            accumulate this cycle
//   i_rate           per-cycle increment (rate in effect)
//   o_tick           combinational; high in the cycle the accumulator wraps
module frac_tick_acc
    import vs_rate_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = DefClkHz
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_rate,
    input  logic       i_run,
    input  logic [7:0] i_rate,
    output logic       o_tick
);

    localparam logic [32:0] Modulus = 33'(CLK_HZ);

    logic [31:0] r_acc;
    logic [31:0] w_acc_next;
    logic [32:0] w_sum;

    always_comb begin
        w_sum      = {1'b0, r_acc} + {25'd0, i_rate};
        o_tick     = i_run && (w_sum >= Modulus);
        w_acc_next = r_acc;
        if (i_load) begin
            // Preloading CLK_HZ - rate makes the very first running cycle wrap.
            w_acc_next = 32'(CLK_HZ) - {24'd0, i_load_rate};
        end else if (i_run) begin
            w_acc_next = o_tick ? 32'(w_sum - Modulus) : w_sum[31:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= 32'd0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/vs_rate_gen.sv
// vs_rate_gen: vertical-sync pacer. Produces VS_WIDTH-cycle vs pulses at fps_cur
// frames per second, spaced by a fractional accumulator.
// Ports:
//   clk50        system clock
//   reset_n      asynchronous active-low reset
//   enable       run request
//   fps_target   requested frames per second (clamped to MAX_FPS)
//   vs           vertical sync, active high, registered
//   frame_start  one-cycle pulse with each vs rising edge
//   fps_cur      rate currently in effect
//   running      high whenever the pacer is not idle
//   overrun      sticky; a tick arrived while vs was high
// MAX_FPS * VS_WIDTH must stay below CLK_HZ, otherwise ticks land inside pulses.
module vs_rate_gen
    import vs_rate_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ   = DefClkHz,
    parameter int unsigned VS_WIDTH = 1000,
    parameter int unsigned MAX_FPS  = 240
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] fps_target,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] fps_cur,
    output logic       running,
    output logic       overrun
);

    localparam int unsigned CntW = (VS_WIDTH > 1) ? $clog2(VS_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(VS_WIDTH - 1);

    vs_state_e       r_state;
    vs_state_e       w_state_next;
    logic [CntW-1:0] r_width_cnt;
    logic [CntW-1:0] w_width_cnt_next;
    logic            r_vs;
    logic            r_frame_start;
    logic [7:0]      r_fps_cur;
    logic [7:0]      w_fps_cur_next;
    logic            r_overrun;
    logic [7:0]      w_eff;
    logic            w_start;
    logic            w_tick;

    assign w_eff   = clamp_fps(fps_target, 8'(MAX_FPS));
    assign w_start = (r_state == StIdle) && enable && (w_eff != 8'd0);

    frac_tick_acc #(
        .CLK_HZ (CLK_HZ)
    ) u_acc (
        .i_clk       (clk50),
        .i_rst_n     (reset_n),
        .i_load      (w_start),
        .i_load_rate (w_eff),
        .i_run       (r_state != StIdle),
        .i_rate      (r_fps_cur),
        .o_tick      (w_tick)
    );

    // FSM state register.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StLow;
                end
            end
            StLow: begin
                // A tick beats a simultaneous enable drop; the pulse then completes.
                if (w_tick) begin
                    w_state_next = (w_eff == 8'd0) ? StIdle : StHigh;
                end else if (!enable) begin
                    w_state_next = StIdle;
                end
            end
            StHigh: begin
                if (r_width_cnt == '0) begin
                    w_state_next = enable ? StLow : StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        running     = (r_state != StIdle);
        vs          = r_vs;
        frame_start = r_frame_start;
        fps_cur     = r_fps_cur;
        overrun     = r_overrun;
    end

    // Width counter and rate register next values.
    always_comb begin
        w_width_cnt_next = r_width_cnt;
        w_fps_cur_next   = r_fps_cur;
        if (w_start) begin
            w_fps_cur_next = w_eff;
        end
        if ((r_state == StLow) && w_tick) begin
            // New rate applies from the next interval; the accumulator carries over.
            w_fps_cur_next   = w_eff;
            w_width_cnt_next = CntLoad;
        end else if ((r_state == StHigh) && (r_width_cnt != '0)) begin
            w_width_cnt_next = r_width_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_vs          <= 1'b0;
            r_frame_start <= 1'b0;
            r_fps_cur     <= 8'd0;
            r_overrun     <= 1'b0;
            r_width_cnt   <= '0;
        end else begin
            r_vs          <= (w_state_next == StHigh);
            r_frame_start <= (r_state == StLow) && (w_state_next == StHigh);
            r_fps_cur     <= w_fps_cur_next;
            r_width_cnt   <= w_width_cnt_next;
            if ((r_state == StHigh) && w_tick) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vs_rate_gen.sv
module tb_vs_rate_gen;

    logic       clk50 = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] fps_target;
    logic       vs;
    logic       frame_start;
    logic [7:0] fps_cur;
    logic       running;
    logic       overrun;

    typedef struct {
        int cyc;
        int fps;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    vs_rate_gen #(
        .CLK_HZ   (1000),
        .VS_WIDTH (4),
        .MAX_FPS  (100)
    ) dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .enable      (enable),
        .fps_target  (fps_target),
        .vs          (vs),
        .frame_start (frame_start),
        .fps_cur     (fps_cur),
        .running     (running),
        .overrun     (overrun)
    );

    always #5 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input int f);
        exp_t e;
        e.cyc = c;
        e.fps = f;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk50);
            n++;
        end
        check({name, "_all_rises_seen"}, q.size(), 0);
        q.delete();
    endtask

    task automatic idle_after(input string name);
        enable = 1'b0;
        repeat (10) @(negedge clk50);
        check({name, "_running_off"}, int'(running), 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_vs"}, int'(vs), 0);
        check({name, "_frame_start"}, int'(frame_start), 0);
        check({name, "_fps_cur"}, int'(fps_cur), 0);
        check({name, "_running"}, int'(running), 0);
        check({name, "_overrun"}, int'(overrun), 0);
    endtask

    // Monitor: every frame_start pops one expected rise; every vs fall checks width.
    initial begin : monitor
        logic prev_vs;
        int   len;
        exp_t e;
        prev_vs = 1'b0;
        len     = 0;
        forever begin
            @(negedge clk50);
            if (!reset_n) begin
                prev_vs = 1'b0;
                len     = 0;
            end else begin
                if (frame_start) begin
                    check("fs_on_vs_rise", int'(vs && !prev_vs), 1);
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_rise: rise at cycle %0d, none expected", cyc);
                    end else begin
                        e = q.pop_front();
                        check("rise_cycle", cyc, e.cyc);
                        check("rise_fps_cur", int'(fps_cur), e.fps);
                    end
                end else if (vs && !prev_vs) begin
                    check("vs_rise_has_fs", 0, 1);
                end
                if (vs && !prev_vs) len = 1;
                else if (vs) len++;
                else if (prev_vs) check("vs_width", len, 4);
                prev_vs = vs;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        int c;
        int t;
        int iv[5];
        iv = '{334, 333, 333, 334, 333};

        reset_n    = 1'b0;
        enable     = 1'b0;
        fps_target = 8'd0;
        repeat (3) @(negedge clk50);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk50);

        // Basic rate: 10 fps -> 100-cycle intervals.
        c = cyc;
        fps_target = 8'd10;
        enable     = 1'b1;
        for (int k = 0; k < 4; k++) push(c + 2 + 100 * k, 10);
        wait_drain("basic", 400);
        idle_after("basic");

        // Fractional: 3 fps -> 334, 333, 333 repeating.
        c = cyc;
        fps_target = 8'd3;
        enable     = 1'b1;
        t = c + 2;
        push(t, 3);
        for (int k = 0; k < 5; k++) begin
            t = t + iv[k];
            push(t, 3);
        end
        wait_drain("frac", 1800);
        idle_after("frac");

        // Clamp: 200 requested -> 100 fps, 10-cycle intervals.
        c = cyc;
        fps_target = 8'd200;
        enable     = 1'b1;
        for (int k = 0; k < 6; k++) push(c + 2 + 10 * k, 100);
        wait_drain("clamp", 100);
        check("clamp_fps_cur", int'(fps_cur), 100);
        check("clamp_overrun", int'(overrun), 0);
        idle_after("clamp");

        // Live change 10 -> 20 at mid-interval.
        c = cyc;
        fps_target = 8'd10;
        enable     = 1'b1;
        push(c + 2, 10);
        push(c + 102, 20);
        push(c + 152, 20);
        push(c + 202, 20);
        repeat (50) @(negedge clk50);
        fps_target = 8'd20;
        wait_drain("live", 250);
        idle_after("live");

        // Disable on the second high cycle: pulse still completes.
        c = cyc;
        fps_target = 8'd10;
        enable     = 1'b1;
        push(c + 2, 10);
        repeat (3) @(negedge clk50);
        enable = 1'b0;
        repeat (2) @(negedge clk50);
        check("dis_vs_4th_cycle", int'(vs), 1);
        @(negedge clk50);
        check("dis_vs_low", int'(vs), 0);
        check("dis_running", int'(running), 0);
        repeat (150) @(negedge clk50);
        check("dis_still_idle", int'(running), 0);
        check("dis_queue", q.size(), 0);

        // Zero rate with enable: stays idle.
        fps_target = 8'd0;
        enable     = 1'b1;
        repeat (3) @(negedge clk50);
        check("zero_running_early", int'(running), 0);
        repeat (50) @(negedge clk50);
        check("zero_running_late", int'(running), 0);
        check("zero_vs", int'(vs), 0);

        // Reset mid-pulse, then restart with basic timing.
        c = cyc;
        fps_target = 8'd10;
        push(c + 2, 10);
        repeat (3) @(negedge clk50);
        check("rst_pre_vs", int'(vs), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (3) @(negedge clk50);
        check_reset_vals("rst_held");
        reset_n = 1'b1;
        c = cyc;
        push(c + 2, 10);
        push(c + 102, 10);
        wait_drain("restart", 250);
        idle_after("restart");

        check("final_overrun", int'(overrun), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
